// File: rtl/usb_pkg.sv
// Shared constants and types for the device-side USB protocol responder.
package usb_pkg;

    localparam logic [7:0]  PID_OUT   = 8'hE1;
    localparam logic [7:0]  PID_IN    = 8'h69;
    localparam logic [7:0]  PID_DATA0 = 8'hC3;
    localparam logic [7:0]  SYNC      = 8'h01;
    localparam logic [18:0] HS_ACK    = 19'h0014b;
    localparam logic [18:0] HS_NAK    = 19'h0015a;

    localparam int PKT_W   = 99;
    localparam int PID_HI  = 18;
    localparam int PID_LO  = 11;
    localparam int ADDR_HI = 10;
    localparam int ADDR_LO = 4;
    localparam int ENDP_HI = 3;
    localparam int ENDP_LO = 0;
    localparam int PAY_HI  = 81;
    localparam int PAY_LO  = 18;
    localparam int HS_HI   = 18;

    typedef enum logic [1:0] {
        KIND_TOKEN = 2'd0,
        KIND_DATA  = 2'd1,
        KIND_HS    = 2'd2
    } kind_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_DATA = 3'd1,
        SEND_HS = 3'd2,
        TX_DATA = 3'd3,
        WAIT_HS = 3'd4
    } state_e;

    function automatic logic [PKT_W-1:0] hs_pkt(input logic nak);
        return {80'd0, (nak ? HS_NAK : HS_ACK)};
    endfunction

    function automatic logic [PKT_W-1:0] data_pkt(input logic [63:0] d);
        return {1'b0, SYNC, PID_DATA0, d, 18'd0};
    endfunction

endpackage

// File: rtl/usb_dev_protocol_rsp_timer.sv
// Response wait counter: cleared on request, counts while enabled,
// flags when the programmed length has been reached.
module rsp_timer #(
    parameter logic [7:0] LEN = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear wins over enable.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (en) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == LEN);

endmodule

// File: rtl/usb_dev_protocol.sv
// Device-side USB protocol responder: answers OUT/IN tokens for one
// address/endpoint, buffers one OUT payload and sends the IN payload.
module usb_dev_protocol
    import usb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h05,
    parameter logic [3:0] ENDP        = 4'h4,
    parameter logic [7:0] TIMEOUT_LEN = 8'd255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [98:0]  pkt_from_dec,
    input  logic [1:0]   pkt_from_dec_kind,
    input  logic         pkt_from_dec_avail,
    input  logic         pkt_from_dec_corrupt,
    input  logic         enc_ready,
    output logic [98:0]  pkt_to_enc,
    output logic         pkt_to_enc_avail,
    output logic         re,
    input  logic [63:0]  tx_data,
    input  logic         tx_data_avail,
    output logic         tx_data_taken,
    output logic [63:0]  rx_data,
    output logic         rx_data_avail,
    input  logic         rx_data_ack,
    output logic [7:0]   nak_count
);

    state_e             state_q, state_d;
    logic [PKT_W-1:0]   pkt_q, pkt_d;
    logic               avail_q, avail_d;
    logic               re_q, re_d;
    logic               nak_sel_q, nak_sel_d;
    logic               taken_q, taken_d;
    logic [63:0]        rx_q, rx_d;
    logic               full_q, full_d;
    logic [7:0]         nak_cnt_q, nak_cnt_d;

    logic               tok_ok_s;
    logic               xfer_s;
    logic               timeout_s;
    logic               timer_clr_s;
    logic               timer_en_s;
    logic [7:0]         pid_s;
    logic               unused_hi;

    assign pid_s     = pkt_from_dec[PID_HI:PID_LO];
    assign tok_ok_s  = pkt_from_dec_avail && (pkt_from_dec_kind == KIND_TOKEN)
                       && !pkt_from_dec_corrupt
                       && (pkt_from_dec[ADDR_HI:ADDR_LO] == DEV_ADDR)
                       && (pkt_from_dec[ENDP_HI:ENDP_LO] == ENDP);
    assign xfer_s    = avail_q && enc_ready;
    assign unused_hi = ^pkt_from_dec[98:82];

    assign timer_clr_s = (state_d != state_q);
    assign timer_en_s  = (state_q == RX_DATA) || (state_q == WAIT_HS);

    rsp_timer #(.LEN(TIMEOUT_LEN)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr_s),
        .en   (timer_en_s),
        .done (timeout_s)
    );

    // Protocol FSM, buffer and NAK counter next-state logic.
    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        nak_sel_d = nak_sel_q;
        taken_d   = 1'b0;
        rx_d      = rx_q;
        nak_cnt_d = nak_cnt_q;
        // Ack clears the flag; an accept below sets it again.
        if (rx_data_ack) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
        case (state_q)
            IDLE: begin
                if (tok_ok_s && (pid_s == PID_OUT)) begin
                    state_d = RX_DATA;
                end else if (tok_ok_s && (pid_s == PID_IN) && tx_data_avail) begin
                    state_d = TX_DATA;
                    pkt_d   = data_pkt(tx_data);
                end else if (tok_ok_s && (pid_s == PID_IN)) begin
                    state_d   = SEND_HS;
                    nak_sel_d = 1'b1;
                    pkt_d     = hs_pkt(1'b1);
                end else begin
                    state_d = IDLE;
                end
            end
            RX_DATA: begin
                if (pkt_from_dec_avail && (pkt_from_dec_kind == KIND_DATA)) begin
                    if (pkt_from_dec_corrupt) begin
                        state_d = IDLE;
                    end else if (!full_q) begin
                        rx_d      = pkt_from_dec[PAY_HI:PAY_LO];
                        full_d    = 1'b1;
                        state_d   = SEND_HS;
                        nak_sel_d = 1'b0;
                        pkt_d     = hs_pkt(1'b0);
                    end else begin
                        state_d   = SEND_HS;
                        nak_sel_d = 1'b1;
                        pkt_d     = hs_pkt(1'b1);
                    end
                end else if (pkt_from_dec_avail || timeout_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RX_DATA;
                end
            end
            SEND_HS: begin
                if (xfer_s) begin
                    state_d = IDLE;
                    if (nak_sel_q && (nak_cnt_q != 8'hFF)) begin
                        nak_cnt_d = nak_cnt_q + 8'd1;
                    end else begin
                        nak_cnt_d = nak_cnt_q;
                    end
                end else begin
                    state_d = SEND_HS;
                end
            end
            TX_DATA: begin
                if (xfer_s) begin
                    state_d = WAIT_HS;
                end else begin
                    state_d = TX_DATA;
                end
            end
            WAIT_HS: begin
                if (pkt_from_dec_avail) begin
                    state_d = IDLE;
                    if ((pkt_from_dec_kind == KIND_HS) && !pkt_from_dec_corrupt
                        && (pkt_from_dec[HS_HI:0] == HS_ACK)) begin
                        taken_d = 1'b1;
                    end else begin
                        taken_d = 1'b0;
                    end
                end else if (timeout_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_HS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Transmitting states hold the encoder request; all others listen.
    always_comb begin
        if ((state_d == SEND_HS) || (state_d == TX_DATA)) begin
            re_d    = 1'b0;
            avail_d = 1'b1;
        end else begin
            re_d    = 1'b1;
            avail_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pkt_q     <= '0;
            avail_q   <= 1'b0;
            re_q      <= 1'b1;
            nak_sel_q <= 1'b0;
            taken_q   <= 1'b0;
            rx_q      <= 64'd0;
            full_q    <= 1'b0;
            nak_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            pkt_q     <= pkt_d;
            avail_q   <= avail_d;
            re_q      <= re_d;
            nak_sel_q <= nak_sel_d;
            taken_q   <= taken_d;
            rx_q      <= rx_d;
            full_q    <= full_d;
            nak_cnt_q <= nak_cnt_d;
        end
    end

    assign pkt_to_enc       = pkt_q;
    assign pkt_to_enc_avail = avail_q;
    assign re               = re_q;
    assign tx_data_taken    = taken_q;
    assign rx_data          = rx_q;
    assign rx_data_avail    = full_q;
    assign nak_count        = nak_cnt_q;

endmodule

// File: tb/tb_usb_dev_protocol.sv
// Directed bench for usb_dev_protocol with hand-computed expected values.
module tb_usb_dev_protocol;

    localparam logic [1:0]  K_TOK = 2'd0;
    localparam logic [1:0]  K_DAT = 2'd1;
    localparam logic [1:0]  K_HS  = 2'd2;
    localparam logic [98:0] ACK_PKT = {80'd0, 19'h0014b};
    localparam logic [98:0] NAK_PKT = {80'd0, 19'h0015a};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [98:0]  pkt_from_dec = '0;
    logic [1:0]   pkt_from_dec_kind = 2'd0;
    logic         pkt_from_dec_avail = 1'b0;
    logic         pkt_from_dec_corrupt = 1'b0;
    logic         enc_ready = 1'b1;
    logic [98:0]  pkt_to_enc;
    logic         pkt_to_enc_avail;
    logic         re;
    logic [63:0]  tx_data = 64'd0;
    logic         tx_data_avail = 1'b0;
    logic         tx_data_taken;
    logic [63:0]  rx_data;
    logic         rx_data_avail;
    logic         rx_data_ack = 1'b0;
    logic [7:0]   nak_count;

    int checks = 0;
    int errors = 0;
    logic [98:0] tx_exp;

    usb_dev_protocol dut (
        .clk                  (clk),
        .rst                  (rst),
        .pkt_from_dec         (pkt_from_dec),
        .pkt_from_dec_kind    (pkt_from_dec_kind),
        .pkt_from_dec_avail   (pkt_from_dec_avail),
        .pkt_from_dec_corrupt (pkt_from_dec_corrupt),
        .enc_ready            (enc_ready),
        .pkt_to_enc           (pkt_to_enc),
        .pkt_to_enc_avail     (pkt_to_enc_avail),
        .re                   (re),
        .tx_data              (tx_data),
        .tx_data_avail        (tx_data_avail),
        .tx_data_taken        (tx_data_taken),
        .rx_data              (rx_data),
        .rx_data_avail        (rx_data_avail),
        .rx_data_ack          (rx_data_ack),
        .nak_count            (nak_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [98:0] got, input logic [98:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] k, input logic [98:0] p, input logic c);
        pkt_from_dec         = p;
        pkt_from_dec_kind    = k;
        pkt_from_dec_corrupt = c;
        pkt_from_dec_avail   = 1'b1;
        tick();
        pkt_from_dec_avail   = 1'b0;
        pkt_from_dec_corrupt = 1'b0;
        pkt_from_dec         = '0;
    endtask

    function automatic logic [98:0] tok(input logic [7:0] pid, input logic [6:0] a, input logic [3:0] e);
        return {80'd0, pid, a, e};
    endfunction

    function automatic logic [98:0] dat(input logic [63:0] d);
        return {17'd0, d, 18'd0};
    endfunction

    initial begin
        // Reset
        tick();
        tick();
        check_val("rst_re", re, 99'd1);
        check_val("rst_avail", pkt_to_enc_avail, 99'd0);
        check_val("rst_pkt", pkt_to_enc, 99'd0);
        check_val("rst_rxav", rx_data_avail, 99'd0);
        check_val("rst_nak", nak_count, 99'd0);
        check_val("rst_taken", tx_data_taken, 99'd0);
        rst = 1'b0;
        tick();

        // OUT + DATA into empty buffer -> ACK
        send(K_TOK, tok(8'hE1, 7'h05, 4'h4), 1'b0);
        check_val("out_tok_avail", pkt_to_enc_avail, 99'd0);
        send(K_DAT, dat(64'hDEADBEEF_01234567), 1'b0);
        check_val("ack1_avail", pkt_to_enc_avail, 99'd1);
        check_val("ack1_pkt", pkt_to_enc, ACK_PKT);
        check_val("ack1_re", re, 99'd0);
        check_val("ack1_rxav", rx_data_avail, 99'd1);
        check_val("ack1_rx", rx_data, {35'd0, 64'hDEADBEEF_01234567});
        tick();
        check_val("ack1_done", pkt_to_enc_avail, 99'd0);
        check_val("ack1_nak", nak_count, 99'd0);

        // Buffer full -> NAK, payload untouched
        send(K_TOK, tok(8'hE1, 7'h05, 4'h4), 1'b0);
        send(K_DAT, dat(64'h11112222_33334444), 1'b0);
        check_val("nak1_pkt", pkt_to_enc, NAK_PKT);
        check_val("nak1_rx", rx_data, {35'd0, 64'hDEADBEEF_01234567});
        tick();
        check_val("nak1_cnt", nak_count, 99'd1);

        // Ack empties, then new payload accepted
        rx_data_ack = 1'b1;
        tick();
        rx_data_ack = 1'b0;
        check_val("ack_clr", rx_data_avail, 99'd0);
        send(K_TOK, tok(8'hE1, 7'h05, 4'h4), 1'b0);
        send(K_DAT, dat(64'hCAFEF00D_55AA33CC), 1'b0);
        check_val("ack2_pkt", pkt_to_enc, ACK_PKT);
        check_val("ack2_rx", rx_data, {35'd0, 64'hCAFEF00D_55AA33CC});
        tick();

        // Ack and data in the same cycle -> NAK, buffer ends empty
        send(K_TOK, tok(8'hE1, 7'h05, 4'h4), 1'b0);
        rx_data_ack = 1'b1;
        send(K_DAT, dat(64'h0F0F0F0F_0F0F0F0F), 1'b0);
        rx_data_ack = 1'b0;
        check_val("race_pkt", pkt_to_enc, NAK_PKT);
        check_val("race_rxav", rx_data_avail, 99'd0);
        check_val("race_rx", rx_data, {35'd0, 64'hCAFEF00D_55AA33CC});
        tick();
        check_val("race_cnt", nak_count, 99'd2);

        // IN with data, encoder stalls 3 cycles
        tx_data       = 64'hA5A5A5A5_A5A5A5A5;
        tx_data_avail = 1'b1;
        enc_ready     = 1'b0;
        tx_exp        = {1'b0, 8'h01, 8'hC3, 64'hA5A5A5A5_A5A5A5A5, 18'd0};
        send(K_TOK, tok(8'h69, 7'h05, 4'h4), 1'b0);
        tx_data = 64'h0;
        for (int i = 0; i < 3; i++) begin
            check_val("tx_hold_avail", pkt_to_enc_avail, 99'd1);
            check_val("tx_hold_pkt", pkt_to_enc, tx_exp);
            tick();
        end
        check_val("tx_4th_avail", pkt_to_enc_avail, 99'd1);
        check_val("tx_4th_pkt", pkt_to_enc, tx_exp);
        enc_ready = 1'b1;
        tick();
        check_val("wait_avail", pkt_to_enc_avail, 99'd0);
        check_val("wait_re", re, 99'd1);
        send(K_HS, ACK_PKT, 1'b0);
        check_val("taken_pulse", tx_data_taken, 99'd1);
        tick();
        check_val("taken_end", tx_data_taken, 99'd0);

        // Host NAKs the IN data -> not taken
        send(K_TOK, tok(8'h69, 7'h05, 4'h4), 1'b0);
        tick();
        send(K_HS, NAK_PKT, 1'b0);
        check_val("hnak_taken", tx_data_taken, 99'd0);
        tx_data_avail = 1'b0;

        // IN without data -> NAK; wrong address ignored
        send(K_TOK, tok(8'h69, 7'h05, 4'h4), 1'b0);
        check_val("in_nak_pkt", pkt_to_enc, NAK_PKT);
        tick();
        check_val("in_nak_cnt", nak_count, 99'd3);
        send(K_TOK, tok(8'h69, 7'h06, 4'h4), 1'b0);
        check_val("badaddr_avail", pkt_to_enc_avail, 99'd0);
        check_val("badaddr_re", re, 99'd1);

        // Data late but inside the window is accepted
        send(K_TOK, tok(8'hE1, 7'h05, 4'h4), 1'b0);
        repeat (254) tick();
        send(K_DAT, dat(64'h12345678_9ABCDEF0), 1'b0);
        check_val("late_pkt", pkt_to_enc, ACK_PKT);
        check_val("late_rx", rx_data, {35'd0, 64'h12345678_9ABCDEF0});
        rx_data_ack = 1'b1;
        tick();
        rx_data_ack = 1'b0;

        // Timeout abandons the OUT transaction
        send(K_TOK, tok(8'hE1, 7'h05, 4'h4), 1'b0);
        repeat (256) tick();
        send(K_DAT, dat(64'h77777777_77777777), 1'b0);
        check_val("tmo_avail", pkt_to_enc_avail, 99'd0);
        check_val("tmo_rxav", rx_data_avail, 99'd0);

        // Corrupt data -> no reply, buffer empty, back in IDLE
        send(K_TOK, tok(8'hE1, 7'h05, 4'h4), 1'b0);
        send(K_DAT, dat(64'h55555555_55555555), 1'b1);
        check_val("crc_avail", pkt_to_enc_avail, 99'd0);
        check_val("crc_rxav", rx_data_avail, 99'd0);
        send(K_DAT, dat(64'h66666666_66666666), 1'b0);
        check_val("crc_idle", pkt_to_enc_avail, 99'd0);

        // NAK counter saturates
        for (int i = 0; i < 300; i++) begin
            send(K_TOK, tok(8'h69, 7'h05, 4'h4), 1'b0);
            tick();
        end
        check_val("nak_sat", nak_count, 99'd255);

        // Reset in the middle of TX_DATA
        tx_data_avail = 1'b1;
        tx_data       = 64'h0BADF00D_0BADF00D;
        enc_ready     = 1'b0;
        send(K_TOK, tok(8'h69, 7'h05, 4'h4), 1'b0);
        check_val("mid_avail", pkt_to_enc_avail, 99'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_avail", pkt_to_enc_avail, 99'd0);
        check_val("mid_rst_re", re, 99'd1);
        check_val("mid_rst_nak", nak_count, 99'd0);
        enc_ready = 1'b1;
        tick();
        check_val("post_rst_avail", pkt_to_enc_avail, 99'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_dev_protocol.md
Name: usb_dev_protocol

Overview:
- Device-side (function) protocol responder for the host-side USB link, sitting between the device's decoder/encoder pair and the device application.
- Accepts IN/OUT tokens addressed to this device and endpoint.
- OUT: receives the data packet into a one-entry buffer and answers ACK or NAK.
- IN: sends the application's 64-bit payload and waits for the host's handshake.

Parameters:
DEV_ADDR, 7'h05, device address matched against the token address field
ENDP, 4'h4, endpoint matched against the token endpoint field
TIMEOUT_LEN, 8'd255, response wait in cycles before abandoning a transaction

Ports:
clk  in  1  clock
rst  in  1  reset
pkt_from_dec  in  99  decoded packet; token/handshake in [18:0], payload in [81:18]
pkt_from_dec_kind  in  2  KIND_TOKEN, KIND_DATA or KIND_HS; valid with avail
pkt_from_dec_avail  in  1  one-cycle strobe: packet present
pkt_from_dec_corrupt  in  1  CRC/stuffing error on the current packet
enc_ready  in  1  encoder accepts pkt_to_enc this cycle
pkt_to_enc  out  99  packet to transmit
pkt_to_enc_avail  out  1  pkt_to_enc valid
re  out  1  receive enable to DPDM; 1 = listening
tx_data  in  64  IN payload from the application
tx_data_avail  in  1  level: tx_data loaded
tx_data_taken  out  1  one-cycle pulse: host ACKed the IN data
rx_data  out  64  latched OUT payload
rx_data_avail  out  1  level: rx buffer full
rx_data_ack  in  1  application consumed rx_data
nak_count  out  8  saturating count of NAKs sent

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - All outputs are 0 except re=1.
  - rx buffer is emptied; nak_count is cleared.
  - Reset mid-transaction abandons it; no handshake is sent.
- Token fields:
  - PID = [18:11], address = [10:4], endpoint = [3:0].
  - A token is valid when avail && kind==KIND_TOKEN && !corrupt && addr==DEV_ADDR && endp==ENDP.
  - Any other token is ignored.
- Handshake test: the handshake is an ACK when [18:0]==HS_ACK.
- Encoder handshake: a transfer completes on the cycle pkt_to_enc_avail && enc_ready. Hold pkt_to_enc stable until then.
- State IDLE (re=1):
  - Valid OUT token (PID_OUT) -> RX_DATA.
  - Valid IN token (PID_IN) with tx_data_avail -> TX_DATA.
  - Valid IN token with !tx_data_avail -> SEND_HS with NAK.
- State RX_DATA (re=1; timer runs):
  - KIND_DATA && corrupt -> IDLE, no reply.
  - KIND_DATA && !corrupt && buffer empty: latch payload [81:18] into rx_data, set rx_data_avail, -> SEND_HS with ACK.
  - KIND_DATA && !corrupt && buffer full -> SEND_HS with NAK; buffer unchanged.
  - Any other packet kind, or timer == TIMEOUT_LEN -> IDLE.
- State SEND_HS (re=0, pkt_to_enc_avail=1):
  - pkt_to_enc = {80'b0, HS_ACK or HS_NAK}, as chosen on entry.
  - On the transfer cycle -> IDLE; nak_count increments if NAK, saturating at 255.
- State TX_DATA (re=0, pkt_to_enc_avail=1):
  - pkt_to_enc = {SYNC, PID_DATA0, tx_data, 18'b0}, captured on entry.
  - On the transfer cycle -> WAIT_HS.
- State WAIT_HS (re=1; timer runs):
  - Uncorrupt ACK -> tx_data_taken pulses 1 cycle, -> IDLE.
  - NAK, corrupt packet, other kind, or timeout -> IDLE, tx_data_taken stays 0 (host retries).
- Buffer:
  - rx_data_ack clears rx_data_avail next cycle.
  - The full/empty decision uses the registered flag, so ack and data arriving in the same cycle produce a NAK.
  - rx_data_ack while empty has no effect.
- Timer: 8-bit, cleared on every state entry, increments in RX_DATA/WAIT_HS. Timeout is exactly TIMEOUT_LEN cycles after entry.
- Latency: decision on the avail cycle; new state next cycle; pkt_to_enc_avail is high the cycle after the token/data strobe.

Decomposition:
- Package usb_pkg holds:
  - PID_OUT 8'hE1, PID_IN 8'h69, PID_DATA0 8'hC3.
  - HS_ACK 19'h014b, HS_NAK 19'h015a, SYNC 8'h01.
  - Field index constants.
  - Kind enum {KIND_TOKEN, KIND_DATA, KIND_HS}.
  - State enum {IDLE, RX_DATA, SEND_HS, TX_DATA, WAIT_HS}.
- Sub-module rsp_timer: 8-bit wait counter with synchronous clear, enable and terminal flag. Shared with future device-side blocks.

Test Plan:
- Valid OUT token, then uncorrupt DATA with payload 64'hDEADBEEF_01234567, buffer empty, enc_ready=1 -> ACK on pkt_to_enc, rx_data_avail=1, rx_data=DEADBEEF_01234567, nak_count=0.
- Repeat the OUT without rx_data_ack -> HS_NAK sent, rx_data unchanged, nak_count=1. Assert rx_data_ack, repeat -> ACK with the new payload.
- IN token with tx_data_avail=1, tx_data=64'hA5A5..., enc_ready held low 3 cycles -> pkt_to_enc_avail held 4 cycles, pkt stable; then ACK from host -> tx_data_taken single pulse.
- IN token with tx_data_avail=0 -> HS_NAK; IN token to address DEV_ADDR+1 -> no response, state stays IDLE.
- OUT token then no data for 255 cycles -> IDLE at cycle 255, no packet sent. OUT token then corrupt DATA -> IDLE, no handshake, buffer empty.
- 300 NAKs -> nak_count=255. Assert rst mid-TX_DATA -> next cycle pkt_to_enc_avail=0, re=1, nak_count=0.
